// File: rtl/stereo_line_pair_buffer.sv
// stereo_line_pair_buffer: ping-pong store of left/right camera lines, streamed out as column-aligned pairs
module stereo_line_pair_buffer #(
    parameter int LINE_W = 640,
    parameter int DATA_W = 8
) (
    input  logic              pixel_clock,
    input  logic              reset_n,
    input  logic              left_valid,
    input  logic              right_valid,
    input  logic [DATA_W-1:0] data,
    input  logic              read_start,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic [9:0]        out_col,
    output logic              out_last,
    output logic              overflow,
    output logic              line_err
);
    localparam int CW = $clog2(LINE_W + 1);
    localparam int AW = $clog2(2 * LINE_W);
    localparam logic [CW-1:0] FULL_CNT = CW'(LINE_W);
    localparam logic [CW-1:0] LAST_CNT = CW'(LINE_W - 1);
    localparam logic [9:0]    LAST_COL = 10'(LINE_W - 1);
    localparam logic [AW-1:0] BANK1 = AW'(LINE_W);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

    logic [DATA_W-1:0] mem_l [2*LINE_W];
    logic [DATA_W-1:0] mem_r [2*LINE_W];
    logic [CW-1:0]     left_cnt, right_cnt;
    logic [1:0]        full, full_next;
    logic              wbank, rbank, eligible;
    state_t            state;
    logic              short_line, complete, want, blocked, commit, free, load;
    logic              wr_l, wr_r;
    logic [AW-1:0]     wl_addr, wr_addr, rd_addr;
    logic [9:0]        rd_col;

    // A line is short when its valid drops before all LINE_W pixels arrived
    assign short_line = (!left_valid && left_cnt != '0 && left_cnt != FULL_CNT) ||
                        (!right_valid && right_cnt != '0 && right_cnt != FULL_CNT);
    assign complete = right_valid && right_cnt == LAST_CNT && !short_line;
    assign want     = complete && (eligible || read_start);
    assign free     = state == STREAM && out_ready && out_last;
    // A bank being released on this very edge can take the new pair
    assign blocked  = full[wbank] && !(free && rbank == wbank);
    assign commit   = want && !blocked;
    // Writes into a full bank are suppressed so a buffered pair is never overwritten
    assign wr_l     = left_valid && left_cnt != FULL_CNT && !full[wbank];
    assign wr_r     = right_valid && right_cnt != FULL_CNT && !full[wbank];
    assign wl_addr  = (wbank ? BANK1 : '0) + AW'(left_cnt);
    assign wr_addr  = (wbank ? BANK1 : '0) + AW'(right_cnt);
    assign rd_col   = state == STREAM ? out_col + 10'd1 : 10'd0;
    assign rd_addr  = (rbank ? BANK1 : '0) + AW'(rd_col);
    assign load     = state == PRIME || (state == STREAM && out_ready && !out_last);

    // Release from the read side and fill from the write side may hit the flags on the same edge
    always_comb begin
        full_next = full;
        if (free) full_next[rbank] = 1'b0;
        if (commit) full_next[wbank] = 1'b1;
    end

    // Pixel storage, both lines of both banks
    always_ff @(posedge pixel_clock) begin
        if (wr_l) mem_l[wl_addr] <= data;
        if (wr_r) mem_r[wr_addr] <= data;
    end

    // Write side: column counters, bank ownership, eligibility and error flags
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            left_cnt  <= '0;
            right_cnt <= '0;
            full      <= '0;
            wbank     <= 1'b0;
            eligible  <= 1'b0;
            overflow  <= 1'b0;
            line_err  <= 1'b0;
        end else begin
            left_cnt  <= !left_valid ? '0 : left_cnt + CW'(left_cnt != FULL_CNT);
            right_cnt <= !right_valid ? '0 : right_cnt + CW'(right_cnt != FULL_CNT);
            full      <= full_next;
            wbank     <= wbank ^ commit;
            eligible  <= !(short_line || complete) && (eligible || read_start);
            overflow  <= overflow || (want && blocked);
            line_err  <= short_line;
        end
    end

    // Read FSM: prime the one-cycle memory read, then stream one pair per accepted beat
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rbank     <= 1'b0;
            out_valid <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (full[rbank]) state <= PRIME;
                PRIME:   begin
                    state     <= STREAM;
                    out_valid <= 1'b1;
                end
                STREAM:  if (free) begin
                    state     <= full[!rbank] ? PRIME : IDLE;
                    rbank     <= !rbank;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (load) begin
                out_left  <= mem_l[rd_addr];
                out_right <= mem_r[rd_addr];
                out_col   <= rd_col;
                out_last  <= rd_col == LAST_COL;
            end
        end
    end
endmodule

// File: tb/tb_stereo_line_pair_buffer.sv
// tb_stereo_line_pair_buffer: randomized stimulus checked against a queue-of-lines reference model
module tb_stereo_line_pair_buffer;
    localparam int LW = 640;
    localparam int DW = 8;
    typedef logic [LW*DW-1:0] line_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          left_valid = 1'b0;
    logic          right_valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic          read_start = 1'b0;
    logic          out_ready = 1'b1;
    logic          out_valid, out_last, overflow, line_err;
    logic [DW-1:0] out_left, out_right;
    logic [9:0]    out_col;

    stereo_line_pair_buffer #(.LINE_W(LW), .DATA_W(DW)) dut (
        .pixel_clock(clk), .reset_n(rst_n), .left_valid(left_valid), .right_valid(right_valid),
        .data(data), .read_start(read_start), .out_ready(out_ready), .out_valid(out_valid),
        .out_left(out_left), .out_right(out_right), .out_col(out_col), .out_last(out_last),
        .overflow(overflow), .line_err(line_err)
    );

    always #5 clk = ~clk;

    int    passed = 0, total = 0;
    line_t ql[$], qr[$];
    line_t st_l, st_r;
    int    exp_col = 0, acc_cnt = 0, err_seen = 0, err_exp = 0;
    int    cyc = 0, first_valid_cyc = 0, last_drive_cyc = 0, ready_mode = 1;
    bit    stalled = 0, prev_ov = 0, exp_ovf = 0, elig = 0, commit_pending = 0, commit_elig = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode[0];
    end

    // Reference model: a queue of whole line pairs; the head is streamed column by column
    always @(negedge clk) if (rst_n) begin
        if (line_err) err_seen++;
        if (out_valid && !prev_ov) first_valid_cyc = cyc;
        if (stalled) check("hold_valid", out_valid, 1);
        if (out_valid) begin
            if (ql.size() == 0) check("spurious_valid", out_valid, 0);
            else begin
                check("pair", {out_left, out_right, out_col, out_last},
                      {ql[0][exp_col*DW +: DW], qr[0][exp_col*DW +: DW], 10'(exp_col), 1'(exp_col == LW-1)});
                if (out_ready) begin
                    exp_col++;
                    acc_cnt++;
                    if (exp_col == LW) begin
                        void'(ql.pop_front());
                        void'(qr.pop_front());
                        exp_col = 0;
                    end
                end
            end
        end
        stalled = out_valid && !out_ready;
        prev_ov = out_valid;
        if (commit_pending) begin
            commit_pending = 0;
            if (commit_elig) begin
                if (ql.size() == 2) exp_ovf = 1;
                else begin
                    ql.push_back(st_l);
                    qr.push_back(st_r);
                end
            end
        end
    end

    task automatic pulse_rs();
        read_start = 1'b1;
        elig = 1;
        tick();
        read_start = 1'b0;
    endtask

    // rs_mode: 0 none, 1 before the left line, 2 between the lines
    task automatic send_pair(input int nl, input int nr, input int rs_mode, input bit rnd);
        logic [DW-1:0] v;
        if (rs_mode == 1) pulse_rs();
        for (int c = 0; c < nl; c++) begin
            v = rnd ? DW'($urandom) : DW'(c);
            left_valid = 1'b1;
            data = v;
            st_l[c*DW +: DW] = v;
            tick();
        end
        left_valid = 1'b0;
        data = '0;
        if (nl > 0 && nl < LW) begin
            err_exp++;
            elig = 0;
        end
        tick();
        tick();
        if (rs_mode == 2) pulse_rs();
        for (int c = 0; c < nr; c++) begin
            v = rnd ? DW'($urandom) : DW'(255 - c);
            right_valid = 1'b1;
            data = v;
            st_r[c*DW +: DW] = v;
            if (c == LW-1) begin
                commit_pending = 1;
                commit_elig = elig;
                elig = 0;
                last_drive_cyc = cyc;
            end
            tick();
        end
        right_valid = 1'b0;
        data = '0;
        tick();
        tick();
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((ql.size() != 0 || out_valid) && n < 20000) begin
            tick();
            n++;
        end
        check(tag, n < 20000, 1);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, n_el, rs;
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", {out_left, out_right}, 0);
        check("rst_col_last", {out_col, out_last}, 0);
        check("rst_flags", {overflow, line_err}, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        acc_cnt = 0;
        send_pair(LW, LW, 2, 0);
        wait_drain("t1_drain");
        check("t1_latency", first_valid_cyc - last_drive_cyc, 3);
        check("t1_accepts", acc_cnt, LW);

        acc_cnt = 0;
        send_pair(LW, LW, 0, 0);
        repeat (10) tick();
        check("t2_no_valid", out_valid, 0);
        check("t2_no_accepts", acc_cnt, 0);
        check("t2_ovf", overflow, 0);
        send_pair(LW, LW, 1, 1);
        wait_drain("t2_drain");
        check("t2_accepts", acc_cnt, LW);

        acc_cnt = 0;
        send_pair(300, LW, 1, 0);
        repeat (10) tick();
        check("t3_line_err", err_seen, err_exp);
        check("t3_no_accepts", acc_cnt, 0);
        send_pair(LW, LW, 2, 1);
        wait_drain("t3_drain");
        check("t3_accepts", acc_cnt, LW);

        ready_mode = 0;
        acc_cnt = 0;
        repeat (3) send_pair(LW, LW, 2, 1);
        repeat (5) tick();
        check("t4_ovf", overflow, exp_ovf);
        check("t4_stalled", {out_valid, out_col}, {1'b1, 10'd0});
        ready_mode = 1;
        wait_drain("t4_drain");
        check("t4_accepts", acc_cnt, 2 * LW);
        check("t4_ovf_sticky", overflow, 1);

        send_pair(LW, LW, 2, 1);
        n = 0;
        while (!(out_valid && out_col == 10'd100) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_col100", n < 3000, 1);
        #1 rst_n = 1'b0;
        ql.delete();
        qr.delete();
        exp_col = 0;
        stalled = 0;
        prev_ov = 0;
        exp_ovf = 0;
        elig = 0;
        commit_pending = 0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_flags", {overflow, out_col}, 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        acc_cnt = 0;
        send_pair(LW, LW, 1, 0);
        wait_drain("t5_drain");
        check("t5_accepts", acc_cnt, LW);

        ready_mode = 2;
        acc_cnt = 0;
        n_el = 0;
        for (int p = 0; p < 5; p++) begin
            n = 0;
            while (ql.size() > 1 && n < 20000) begin
                tick();
                n++;
            end
            check("t6_space", n < 20000, 1);
            rs = $urandom_range(0, 2);
            if (rs != 0) n_el++;
            send_pair(LW, LW, rs, 1);
        end
        wait_drain("t6_drain");
        check("t6_accepts", acc_cnt, n_el * LW);
        check("t6_ovf", overflow, exp_ovf);
        check("line_err_total", err_seen, err_exp);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/stereo_line_pair_buffer.md
STEREO_LINE_PAIR_BUFFER -- requirements
Module: stereo_line_pair_buffer

Interface
REQ-001 SHALL have parameter LINE_W, default 640, meaning pixels per left line and per right line.
REQ-002 SHALL have parameter DATA_W, default 8, meaning pixel width.
REQ-003 SHALL have port pixel_clock, input, 1 bit: the single clock; all logic rises on it.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port left_valid, input, 1 bit: data carries a left-line pixel this cycle.
REQ-006 SHALL have port right_valid, input, 1 bit: data carries a right-line pixel this cycle.
REQ-007 SHALL have port data, input, DATA_W bits: pixel value from the camera stage.
REQ-008 SHALL have port read_start, input, 1 bit: single-cycle pulse marking the current line pair as eligible for output.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the output pair.
REQ-010 SHALL have port out_valid, output, 1 bit: the out_left, out_right, out_col and out_last outputs are valid.
REQ-011 SHALL have port out_left, output, DATA_W bits: left pixel at out_col.
REQ-012 SHALL have port out_right, output, DATA_W bits: right pixel at out_col.
REQ-013 SHALL have port out_col, output, 10 bits: column 0..LINE_W-1.
REQ-014 SHALL have port out_last, output, 1 bit: high with column LINE_W-1.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag; a completed eligible pair was dropped.
REQ-016 SHALL have port line_err, output, 1 bit: one-cycle pulse; a short line was discarded.

Function
REQ-017 SHALL hold two banks (ping-pong), each storing one left line and one right line of LINE_W x DATA_W.
REQ-018 SHALL write each left_valid pixel to the write bank at a left column counter; the counter starts at 0 and increments per write.
REQ-019 SHALL reset the left column counter to 0 on the cycle left_valid falls.
REQ-020 SHALL store right pixels the same way with an independent right column counter.
REQ-021 SHALL ignore writes beyond column LINE_W-1 and set no flag for them.
REQ-022 SHALL latch read_start into an eligible flag, cleared when the pair commits or is discarded.
REQ-023 SHALL commit a pair on the cycle the right column counter reaches LINE_W with the eligible flag set or read_start high; the bank becomes full and the write bank toggles next cycle.
REQ-024 SHALL discard a completed pair that is not eligible, leaving the write bank unchanged.
REQ-025 SHALL treat a left_valid or right_valid falling edge with its counter between 1 and LINE_W-1 as a short line: pulse line_err, discard the pair and clear the eligible flag.
REQ-026 SHALL, if a pair commits while both banks are full, drop that pair, set overflow and keep the write bank unchanged.
REQ-027 SHALL run the read FSM states IDLE, PRIME and STREAM.
REQ-028 SHALL go IDLE->PRIME when the read bank is full.
REQ-029 SHALL go PRIME->STREAM after one cycle (memory read latency 1).
REQ-030 SHALL go STREAM->IDLE when the column LINE_W-1 pair is accepted, free the bank and toggle the read bank.
REQ-031 SHALL, if the other bank is already full at that point, enter PRIME on the next cycle.
REQ-032 SHALL count an output pair as accepted only when out_valid and out_ready are both high.
REQ-033 SHALL hold all out_* stable while out_valid=1 and out_ready=0, and SHALL NOT drop out_valid before acceptance.
REQ-034 SHALL sustain one pair per cycle with out_ready held high; first out_valid 2 cycles after the bank becomes full.
REQ-035 SHALL let writing and reading proceed on opposite banks simultaneously with no interaction.
REQ-036 SHALL let a bank freed and committed in the same cycle count as full, with no overflow.

Reset
REQ-037 SHALL, while reset_n=0, set out_valid=0, out_left=0, out_right=0, out_col=0, out_last=0, overflow=0 and line_err=0.
REQ-038 SHALL, while reset_n=0, empty both banks, select bank 0 for write and read, clear both column counters and the eligible flag, and set the FSM to IDLE.
REQ-039 SHALL, on reset mid-line or mid-stream, abandon all buffered data; memory contents need not be cleared.

Verification
REQ-040 Stimulus: 640 left pixels (data=col), gap, read_start pulse, 640 right pixels (data=255-col), out_ready=1. Response: 640 pairs with out_left=col and out_right=255-col; out_last only at col 639; first out_valid 2 cycles after the 640th right write.
REQ-041 Stimulus: same pair with no read_start. Response: no out_valid; overflow=0; next eligible pair is emitted from bank 0.
REQ-042 Stimulus: left_valid drops after 300 pixels. Response: line_err pulse; no output; next full pair is correct.
REQ-043 Stimulus: out_ready=0, three eligible pairs written. Response: pairs 1 and 2 buffered, pair 3 dropped with overflow=1; releasing out_ready emits pairs 1 then 2 intact.
REQ-044 Stimulus: out_ready toggled randomly. Response: outputs stable while stalled; every column emitted exactly once, in order.
REQ-045 Stimulus: reset_n asserted at stream column 100. Response: out_valid=0 immediately; after release, the first new eligible pair streams from column 0.
